// File: rtl/clk_tick_monitor.sv
// clk_tick_monitor: measures the half-period of an asynchronous slow square
// wave in clk_in cycles, flags out-of-tolerance measurements and stalls.
// Optional build macro CLK_TICK_MONITOR_EDGE_CNT_EN enables the 16-bit
// edge counter; without it edge_count is tied to zero.
//
// state | meaning
// IDLE  | after reset, no edge seen yet; first edge is never measured
// TRACK | at least one edge seen; each further edge yields a measurement
// FAULT | no edge for TIMEOUT cycles; stall asserted, next edge unmeasured
module clk_tick_monitor #(
   parameter int EXP_HALF = 1000001,
   parameter int TOL      = 16,
   parameter int TIMEOUT  = 2000002
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        clk_slow,
   input  logic        clr,
   output logic        rise_pulse,
   output logic        fall_pulse,
   output logic [21:0] half_period,
   output logic        meas_valid,
   output logic        err_freq,
   output logic        stall,
   output logic [15:0] edge_count
);

   localparam logic [21:0] CNT_MAX = '1;
   localparam logic [21:0] LIM_HI  = 22'(EXP_HALF + TOL);
   localparam logic [21:0] LIM_LO  = (TOL >= EXP_HALF) ? 22'd0 : 22'(EXP_HALF - TOL);
   localparam logic [21:0] TMO     = 22'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        s1_q, s2_q, s3_q;
   logic        edge_det;
   logic [21:0] cnt_q, cnt_d;
   logic        meas;
   logic        out_of_tol;
   logic        rise_q, fall_q, mv_q, err_q, err_d;
   logic [21:0] hp_q, hp_d;

   assign edge_det   = s2_q ^ s3_q;
   assign out_of_tol = (cnt_q > LIM_HI) || (cnt_q < LIM_LO);

   // Two-flop synchroniser plus history flop for edge detection.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= clk_slow;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Interval counter restarts at 1 on every edge and saturates at full scale.
   always_comb begin
      cnt_d = cnt_q;
      if (edge_det)
         cnt_d = 22'd1;
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + 22'd1;
   end

   // Next-state logic; an edge always takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      meas    = 1'b0;
      case (state_q)
         IDLE: begin
            if (edge_det)
               state_d = TRACK;
            else if (cnt_q >= TMO)
               state_d = FAULT;
         end
         TRACK: begin
            if (edge_det)
               meas = 1'b1;
            else if (cnt_q >= TMO)
               state_d = FAULT;
         end
         FAULT: begin
            if (edge_det)
               state_d = TRACK;
         end
         default: state_d = IDLE;
      endcase
   end

   // Measurement capture and sticky error; a new error outranks clr.
   always_comb begin
      hp_d  = meas ? cnt_q : hp_q;
      err_d = err_q;
      if (meas && out_of_tol)
         err_d = 1'b1;
      else if (clr)
         err_d = 1'b0;
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         mv_q    <= 1'b0;
         hp_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= s2_q & ~s3_q;
         fall_q  <= ~s2_q & s3_q;
         mv_q    <= meas;
         hp_q    <= hp_d;
         err_q   <= err_d;
      end
   end

   assign rise_pulse  = rise_q;
   assign fall_pulse  = fall_q;
   assign meas_valid  = mv_q;
   assign half_period = hp_q;
   assign err_freq    = err_q;
   assign stall       = (state_q == FAULT);

`ifdef CLK_TICK_MONITOR_EDGE_CNT_EN
   logic [15:0] ecnt_q;

   // Free-running edge counter, wraps naturally at 16 bits.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)
         ecnt_q <= '0;
      else if (edge_det)
         ecnt_q <= ecnt_q + 16'd1;
   end

   assign edge_count = ecnt_q;
`else
   assign edge_count = '0;
`endif

endmodule

// File: tb/tb_clk_tick_monitor.sv
// Testbench for clk_tick_monitor with EXP_HALF=10, TOL=1, TIMEOUT=25.
// The reference model reasons only about the time between clk_slow toggles
// driven by the bench: an edge is measured when a previous edge exists since
// reset/stall and the gap did not exceed TIMEOUT; strobes appear a fixed
// three clk_in cycles after the toggle.
module tb_clk_tick_monitor;
   localparam int EXP_HALF = 10;
   localparam int TOL      = 1;
   localparam int TIMEOUT  = 25;

   logic        clk_in = 1'b0;
   logic        rst = 1'b0;
   logic        clk_slow = 1'b0;
   logic        clr = 1'b0;
   logic        rise_pulse, fall_pulse, meas_valid, err_freq, stall;
   logic [21:0] half_period;
   logic [15:0] edge_count;

   int checks = 0;
   int failures = 0;

   bit          have_prev = 1'b0;
   int          prev_gap = 0;
   bit          ref_err = 1'b0;
   logic [21:0] ref_hp = '0;
   bit          level = 1'b0;
   int          ref_edges = 0;

   always #5 clk_in = ~clk_in;

   clk_tick_monitor #(
      .EXP_HALF (EXP_HALF),
      .TOL      (TOL),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .clk_slow    (clk_slow),
      .clr         (clr),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .half_period (half_period),
      .meas_valid  (meas_valid),
      .err_freq    (err_freq),
      .stall       (stall),
      .edge_count  (edge_count)
   );

   function automatic logic [15:0] exp_ecnt();
`ifdef CLK_TICK_MONITOR_EDGE_CNT_EN
      return 16'(ref_edges);
`else
      return 16'd0;
`endif
   endfunction

   // Toggle clk_slow now (at a negedge), hold it for gap cycles, and check
   // strobes/measurement. mode 1: clr pulse in a quiet cycle; mode 2: clr
   // coincides with the measurement cycle.
   task automatic step(input int gap, input int mode);
      bit measured, bad, exp_stall;
      if (have_prev) begin
         exp_stall = (prev_gap - 3 >= TIMEOUT);
         checks++;
         if (stall !== exp_stall) begin
            failures++;
            $display("FAIL stall_before_edge got=%b exp=%b gap=%0d", stall, exp_stall, prev_gap);
         end
      end
      measured = have_prev && (prev_gap <= TIMEOUT);
      bad = measured && ((prev_gap > EXP_HALF + TOL) || (prev_gap < EXP_HALF - TOL));
      level = ~level;
      clk_slow = level;
      ref_edges++;
      if (measured) ref_hp = 22'(prev_gap);
      if (mode == 2) ref_err = bad;
      else if (bad) ref_err = 1'b1;
      for (int i = 1; i <= gap; i++) begin
         @(negedge clk_in);
         if (i == 2 && mode == 2) clr = 1'b1;
         if (i == 3) begin
            if (mode == 2) clr = 1'b0;
            checks++;
            if (rise_pulse !== level) begin
               failures++;
               $display("FAIL rise_pulse got=%b exp=%b", rise_pulse, level);
            end
            checks++;
            if (fall_pulse !== ~level) begin
               failures++;
               $display("FAIL fall_pulse got=%b exp=%b", fall_pulse, ~level);
            end
            checks++;
            if (meas_valid !== measured) begin
               failures++;
               $display("FAIL meas_valid got=%b exp=%b prev_gap=%0d", meas_valid, measured, prev_gap);
            end
            checks++;
            if (half_period !== ref_hp) begin
               failures++;
               $display("FAIL half_period got=%0d exp=%0d", half_period, ref_hp);
            end
            checks++;
            if (err_freq !== ref_err) begin
               failures++;
               $display("FAIL err_freq got=%b exp=%b prev_gap=%0d mode=%0d", err_freq, ref_err, prev_gap, mode);
            end
            checks++;
            if (stall !== 1'b0) begin
               failures++;
               $display("FAIL stall_after_edge got=%b exp=0", stall);
            end
            checks++;
            if (edge_count !== exp_ecnt()) begin
               failures++;
               $display("FAIL edge_count got=%0d exp=%0d", edge_count, exp_ecnt());
            end
         end
         if (i == 4) begin
            checks++;
            if ({rise_pulse, fall_pulse, meas_valid} !== 3'b000) begin
               failures++;
               $display("FAIL strobe_width got=%b%b%b exp=000", rise_pulse, fall_pulse, meas_valid);
            end
            checks++;
            if (half_period !== ref_hp) begin
               failures++;
               $display("FAIL half_period_hold got=%0d exp=%0d", half_period, ref_hp);
            end
            if (mode == 1) clr = 1'b1;
         end
         if (i == 5 && mode == 1) begin
            clr = 1'b0;
            ref_err = 1'b0;
            checks++;
            if (err_freq !== 1'b0) begin
               failures++;
               $display("FAIL err_clr got=%b exp=0", err_freq);
            end
         end
         if (gap >= TIMEOUT + 4 && i == TIMEOUT + 2) begin
            checks++;
            if (stall !== 1'b0) begin
               failures++;
               $display("FAIL stall_early got=%b exp=0", stall);
            end
         end
         if (gap >= TIMEOUT + 4 && i == TIMEOUT + 3) begin
            checks++;
            if (stall !== 1'b1) begin
               failures++;
               $display("FAIL stall_at_timeout got=%b exp=1", stall);
            end
         end
      end
      have_prev = 1'b1;
      prev_gap = gap;
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst = 1'b0;
      clk_slow = 1'b0;
      clr = 1'b0;
      level = 1'b0;
      have_prev = 1'b0;
      ref_err = 1'b0;
      ref_hp = '0;
      ref_edges = 0;
      #1;
      checks++;
      if ({rise_pulse, fall_pulse, meas_valid, err_freq, stall} !== 5'b0 ||
          half_period !== 22'd0 || edge_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b%b%b%b%b hp=%0d ec=%0d exp=all zero",
                  rise_pulse, fall_pulse, meas_valid, err_freq, stall, half_period, edge_count);
      end
      repeat (3) @(negedge clk_in);
      rst = 1'b1;
      repeat (2) @(negedge clk_in);
      checks++;
      if ({rise_pulse, fall_pulse, meas_valid, err_freq, stall} !== 5'b0 ||
          half_period !== 22'd0 || edge_count !== 16'd0) begin
         failures++;
         $display("FAIL post_reset_outputs got=%b%b%b%b%b hp=%0d ec=%0d exp=all zero",
                  rise_pulse, fall_pulse, meas_valid, err_freq, stall, half_period, edge_count);
      end
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_nominal();
      for (int i = 0; i < 5; i++) step(10, 0);
   endtask

   task automatic test_tolerance();
      step(9, 0);
      step(11, 0);
      step(12, 0);
      step(10, 0);
      step(10, 1);
      step(10, 0);
      step(10, 0);
   endtask

   task automatic test_clr_coincide();
      step(12, 0);
      step(10, 2);
      step(10, 1);
      step(10, 2);
      step(8, 0);
      step(10, 0);
      step(10, 1);
   endtask

   task automatic test_stall();
      step(10, 0);
      step(40, 0);
      step(10, 0);
      step(10, 0);
      step(10, 0);
   endtask

   task automatic test_reset_mid();
      step(10, 0);
      step(11, 0);
      level = ~level;
      clk_slow = level;
      repeat (6) @(negedge clk_in);
      clk_slow = ~clk_slow;
      repeat (2) @(negedge clk_in);
      do_reset();
      step(10, 0);
      step(10, 0);
      step(10, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         step(int'($urandom_range(6, 32)), int'($urandom_range(0, 2)));
   endtask

   task automatic test_edge_count();
      int n;
      logic [15:0] exp;
`ifdef CLK_TICK_MONITOR_EDGE_CNT_EN
      n = 65537;
`else
      n = 300;
`endif
      do_reset();
      for (int i = 0; i < n; i++) begin
         clk_slow = ~clk_slow;
         ref_edges++;
         @(negedge clk_in);
      end
      repeat (4) @(negedge clk_in);
      exp = exp_ecnt();
      checks++;
      if (edge_count !== exp) begin
         failures++;
         $display("FAIL edge_count_wrap got=%0d exp=%0d edges=%0d", edge_count, exp, n);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_tolerance();
      test_clr_coincide();
      test_stall();
      test_reset_mid();
      test_random();
      test_edge_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_tick_monitor.md
CLK_TICK_MONITOR -- requirements
Module: clk_tick_monitor

Interface
REQ-001 SHALL have parameter EXP_HALF, default 1000001, expected half-period of clk_slow in clk_in cycles.
REQ-002 SHALL have parameter TOL, default 16, allowed +/- deviation from EXP_HALF in cycles.
REQ-003 SHALL have parameter TIMEOUT, default 2000002, number of edge-free cycles that declares a stall.
REQ-004 SHALL have port clk_in  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset; asserted when rst==0.
REQ-006 SHALL have port clk_slow  input  1  asynchronous slow square wave under monitor.
REQ-007 SHALL have port clr  input  1  synchronous clear of sticky err_freq.
REQ-008 SHALL have port rise_pulse  output  1  one-cycle strobe per detected rising edge.
REQ-009 SHALL have port fall_pulse  output  1  one-cycle strobe per detected falling edge.
REQ-010 SHALL have port half_period  output  22  last measured edge-to-edge interval in clk_in cycles.
REQ-011 SHALL have port meas_valid  output  1  one-cycle strobe when half_period updates.
REQ-012 SHALL have port err_freq  output  1  sticky: a measurement fell outside EXP_HALF+/-TOL.
REQ-013 SHALL have port stall  output  1  level: no edge seen for TIMEOUT cycles.
REQ-014 SHALL have port edge_count  output  16  total detected edges (see Configuration).

Function
REQ-015 SHALL synchronise clk_slow through two flops (s1,s2) plus history flop s3; edge = s2 XOR s3.
REQ-016 SHALL assert rise_pulse when s2=1,s3=0 and fall_pulse when s2=0,s3=1, each for exactly one cycle; latency from clk_slow change to strobe 2-3 clk_in cycles.
REQ-017 SHALL run 22-bit interval counter cnt: on edge cycle cnt<=1, else cnt<=cnt+1, saturating at 2^22-1.
REQ-018 SHALL implement FSM IDLE -> TRACK -> FAULT: IDLE after reset; first edge IDLE->TRACK with no measurement; TRACK edge -> stay TRACK with measurement.
REQ-019 SHALL, on each edge in TRACK, load half_period<=cnt and pulse meas_valid the same cycle half_period updates.
REQ-020 SHALL set err_freq on a measurement with |cnt-EXP_HALF|>TOL; boundary values EXP_HALF+/-TOL exactly are in tolerance.
REQ-021 SHALL enter FAULT from IDLE or TRACK when cnt reaches TIMEOUT without an edge; stall=1 exactly in FAULT.
REQ-022 SHALL leave FAULT to TRACK on next edge, no measurement on that edge, stall deasserting the following cycle.
REQ-023 SHALL clear err_freq when clr=1; if set condition and clr coincide, set wins.
REQ-024 SHALL keep half_period unchanged except on measurement cycles.

Reset
REQ-025 SHALL, while rst==0, force s1,s2,s3=0, cnt=0, state=IDLE, half_period=0, all strobes/flags=0, edge_count=0.
REQ-026 SHALL treat a reset mid-measurement as discarding it; first post-reset edge is never measured.

Configuration
REQ-027 SHALL compile edge counter only when macro CLK_TICK_MONITOR_EDGE_CNT_EN is defined: edge_count increments on each detected edge, wraps 65535->0.
REQ-028 SHALL, without CLK_TICK_MONITOR_EDGE_CNT_EN, keep port edge_count present and tied to 0.

Verification (EXP_HALF=10, TOL=1, TIMEOUT=25)
REQ-029 SHALL check: clk_slow toggling every 10 clk_in cycles -> first edge no meas_valid; subsequent edges half_period=10, meas_valid pulses, err_freq=0.
REQ-030 SHALL check: half-periods 9 and 11 -> err_freq=0; half-period 12 -> err_freq=1 held; clr pulse -> err_freq=0 next cycle.
REQ-031 SHALL check: clk_slow held 25+ cycles -> stall=1; next edge -> stall=0, no meas_valid on that edge, following edge measured.
REQ-032 SHALL check: rst=0 mid half-period -> all outputs 0; after release first edge unmeasured.
REQ-033 SHALL check: clr asserted in same cycle as out-of-tolerance measurement -> err_freq=1.
REQ-034 SHALL check: with CLK_TICK_MONITOR_EDGE_CNT_EN, 65537 edges -> edge_count=1; without macro -> edge_count=0 throughout.
